seq_fsm: RTL and testbench

- Parametrised successor of the two-state output-alternator FSM.
- Steps through a programmable table of STEPS output words of WIDTH bits.
- Per-step dwell time, three sequencing modes (wrap, ping-pong, one-shot), start/stop control and busy/done status.
- Sits beside the control datapath as a pattern/sequence source; reset-default table reproduces the 1,2,1,2… alternation.

---
 rtl/seq_fsm.sv | 148 ++++++++++++++
 tb/tb_seq_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fsm.sv
// seq_fsm: programmable step-sequence source with dwell,
// wrap/ping-pong/one-shot modes, start/stop and busy/done status.
//
// Ports:
//   clk, rst        rising-edge clock, async active-low reset
//   en              advance qualifier (freezes dwell and step)
//   start, stop     run control (start in IDLE, stop in RUN)
//   mode            00 wrap, 01 ping-pong, 10 one-shot, 11 wrap
//   dwell           each step lasts dwell+1 en cycles
//   wr_en/idx/data  table write port
//   salida          current step word (0 when idle)
//   step            current step index
//   busy, done      running flag, one-shot completion pulse
module seq_fsm #(
  parameter int WIDTH   = 2,
  parameter int STEPS   = 2,
  parameter int DWELL_W = 4,
  localparam int IDXW   = (STEPS > 2) ? $clog2(STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   salida,
  output logic [IDXW-1:0]    step,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [IDXW-1:0] LAST =
    IDXW'(STEPS - 1);
  localparam logic [IDXW:0] NSTEPS =
    (IDXW + 1)'(STEPS);

  state_t             state;
  logic [WIDTH-1:0]   tbl [STEPS];
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_l;
  logic [1:0]         mode_l;
  logic               dir_dn;

  logic [IDXW-1:0]    nxt_step;
  logic               nxt_dn;
  logic               fin;
  logic               wr_ok;

  // Indices past the table end are silently dropped.
  assign wr_ok = wr_en && ({1'b0, wr_idx} < NSTEPS);

  always_comb begin
    nxt_step = step + IDXW'(1);
    nxt_dn   = dir_dn;
    fin      = 1'b0;
    unique case (1'b1)
      mode_l == 2'b01: begin
        if (dir_dn) begin
          nxt_step = step - IDXW'(1);
          if (step == IDXW'(1))
            nxt_dn = 1'b0;
        end else if (step + IDXW'(1) == LAST) begin
          nxt_dn = 1'b1;
        end
      end
      mode_l == 2'b10: begin
        fin = (step == LAST);
      end
      default: begin
        if (step == LAST)
          nxt_step = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      salida  <= '0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      dwell_l <= '0;
      mode_l  <= 2'b00;
      dir_dn  <= 1'b0;
      for (int i = 0; i < STEPS; i++)
        tbl[i] <= WIDTH'(i + 1);
    end else begin
      done <= 1'b0;
      // salida below reads the pre-write value,
      // so a same-edge write is seen only on re-entry.
      if (wr_ok)
        tbl[wr_idx] <= wr_data;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            step    <= '0;
            salida  <= tbl[0];
            busy    <= 1'b1;
            cnt     <= '0;
            dir_dn  <= 1'b0;
            mode_l  <= mode;
            dwell_l <= dwell;
          end
        end
        RUN: begin
          if (stop) begin
            state  <= IDLE;
            salida <= '0;
            step   <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
          end else if (en) begin
            if (cnt != dwell_l) begin
              cnt <= cnt + DWELL_W'(1);
            end else begin
              cnt <= '0;
              if (fin) begin
                state  <= IDLE;
                salida <= '0;
                step   <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                step   <= nxt_step;
                dir_dn <= nxt_dn;
                salida <= tbl[nxt_step];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fsm.sv
// tb_seq_fsm: directed bench for seq_fsm with three
// parameter sets (2x2 default, 4x4, 4-bit x 3 steps).
module tb_seq_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] dwell;

  logic       wr_en0;
  logic [0:0] wr_idx0;
  logic [1:0] wr_data0;
  logic [1:0] sal0;
  logic [0:0] step0;
  logic       busy0;
  logic       done0;

  logic       wr_en1;
  logic [1:0] wr_idx1;
  logic [3:0] wr_data1;
  logic [3:0] sal1;
  logic [1:0] step1;
  logic       busy1;
  logic       done1;

  logic       wr_en2;
  logic [1:0] wr_idx2;
  logic [3:0] wr_data2;
  logic [3:0] sal2;
  logic [1:0] step2;
  logic       busy2;
  logic       done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_fsm u0 (
    .clk(clk), .rst(rst), .en(en),
    .start(start), .stop(stop),
    .mode(mode), .dwell(dwell),
    .wr_en(wr_en0), .wr_idx(wr_idx0),
    .wr_data(wr_data0), .salida(sal0),
    .step(step0), .busy(busy0), .done(done0)
  );

  seq_fsm #(.WIDTH(4), .STEPS(4)) u1 (
    .clk(clk), .rst(rst), .en(en),
    .start(start), .stop(stop),
    .mode(mode), .dwell(dwell),
    .wr_en(wr_en1), .wr_idx(wr_idx1),
    .wr_data(wr_data1), .salida(sal1),
    .step(step1), .busy(busy1), .done(done1)
  );

  seq_fsm #(.WIDTH(4), .STEPS(3)) u2 (
    .clk(clk), .rst(rst), .en(en),
    .start(start), .stop(stop),
    .mode(mode), .dwell(dwell),
    .wr_en(wr_en2), .wr_idx(wr_idx2),
    .wr_data(wr_data2), .salida(sal2),
    .step(step2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1;
    start = 1'b0; stop = 1'b0;
    mode = 2'b00; dwell = 4'd0;
    wr_en0 = 1'b0; wr_idx0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_idx1 = '0; wr_data1 = '0;
    wr_en2 = 1'b0; wr_idx2 = '0; wr_data2 = '0;
    tick(); tick();
    total++;
    if ({sal0, step0, busy0, done0} !== 5'd0) begin
      bad++;
      $display("FAIL reset_u0 got=%b want=0",
               {sal0, step0, busy0, done0});
    end
    total++;
    if ({sal1, step1, busy1, done1} !== 8'd0) begin
      bad++;
      $display("FAIL reset_u1 got=%b want=0",
               {sal1, step1, busy1, done1});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wrap_default();
    mode = 2'b00; dwell = 4'd0; en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sal0 !== 2'((k % 2) + 1) || busy0 !== 1'b1)
      begin
        bad++;
        $display("FAIL wrap_u0[%0d] sal=%0d busy=%b want=%0d 1",
                 k, sal0, busy0, (k % 2) + 1);
      end
      if (k < 4) tick();
    end
    halt();
  endtask

  task automatic test_pingpong();
    int es [15];
    int ep [15];
    int e2 [15];
    es = '{3,3,5,5,7,7,9,9,7,7,5,5,3,3,5};
    ep = '{0,0,1,1,2,2,3,3,2,2,1,1,0,0,1};
    e2 = '{0,0,1,1,2,2,1,1,0,0,1,1,2,2,1};
    for (int i = 0; i < 4; i++) begin
      wr_en1 = 1'b1;
      wr_idx1 = 2'(i);
      wr_data1 = 4'(2 * i + 3);
      tick();
    end
    wr_en1 = 1'b0;
    mode = 2'b01; dwell = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'b00; dwell = 4'd0;
    for (int k = 0; k < 15; k++) begin
      total++;
      if (sal1 !== 4'(es[k]) || step1 !== 2'(ep[k])) begin
        bad++;
        $display("FAIL pp4[%0d] sal=%0d step=%0d want=%0d %0d",
                 k, sal1, step1, es[k], ep[k]);
      end
      total++;
      if (step2 !== 2'(e2[k])) begin
        bad++;
        $display("FAIL pp3[%0d] step=%0d want=%0d",
                 k, step2, e2[k]);
      end
      tick();
    end
    halt();
  endtask

  task automatic test_oneshot();
    int es [4];
    es = '{3,5,7,9};
    mode = 2'b10; dwell = 4'd0; en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sal1 !== 4'(es[k]) || busy1 !== 1'b1 ||
          done1 !== 1'b0) begin
        bad++;
        $display("FAIL os[%0d] sal=%0d busy=%b done=%b want=%0d 1 0",
                 k, sal1, busy1, done1, es[k]);
      end
      if (k < 3) tick();
    end
    start = 1'b1;
    tick();
    total++;
    if (sal1 !== 4'd0 || busy1 !== 1'b0 ||
        done1 !== 1'b1 || step1 !== 2'd0) begin
      bad++;
      $display("FAIL os_done sal=%0d busy=%b done=%b want=0 0 1",
               sal1, busy1, done1);
    end
    tick();
    start = 1'b0;
    total++;
    if (sal1 !== 4'd3 || busy1 !== 1'b1 ||
        done1 !== 1'b0) begin
      bad++;
      $display("FAIL os_restart sal=%0d busy=%b done=%b want=3 1 0",
               sal1, busy1, done1);
    end
    halt();
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL os_stop busy=%b done=%b want=0 0",
               busy1, done1);
    end
  endtask

  task automatic test_en_and_writes();
    int es [4];
    int ep [4];
    es = '{9,3,12,14};
    ep = '{3,0,1,2};
    mode = 2'b00; dwell = 4'd0; en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    en = 1'b0;
    wr_en1 = 1'b1; wr_idx1 = 2'd1; wr_data1 = 4'd12;
    tick();
    wr_en1 = 1'b0;
    total++;
    if (sal1 !== 4'd5 || step1 !== 2'd1) begin
      bad++;
      $display("FAIL en_hold1 sal=%0d step=%0d want=5 1",
               sal1, step1);
    end
    tick();
    total++;
    if (sal1 !== 4'd5 || step1 !== 2'd1) begin
      bad++;
      $display("FAIL en_hold2 sal=%0d step=%0d want=5 1",
               sal1, step1);
    end
    en = 1'b1;
    wr_en1 = 1'b1; wr_idx1 = 2'd2; wr_data1 = 4'd14;
    tick();
    wr_en1 = 1'b0;
    total++;
    if (sal1 !== 4'd7 || step1 !== 2'd2) begin
      bad++;
      $display("FAIL wr_same_edge sal=%0d step=%0d want=7 2",
               sal1, step1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (sal1 !== 4'(es[k]) || step1 !== 2'(ep[k])) begin
        bad++;
        $display("FAIL en_run[%0d] sal=%0d step=%0d want=%0d %0d",
                 k, sal1, step1, es[k], ep[k]);
      end
    end
    halt();
  endtask

  task automatic test_stop_start_and_drop();
    int es [4];
    es = '{1,2,3,1};
    mode = 2'b00; dwell = 4'd0; en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if (sal1 !== 4'd0 || step1 !== 2'd0 ||
        busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL stop_start sal=%0d busy=%b done=%b want=0 0 0",
               sal1, busy1, done1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy1 !== 1'b0 || sal1 !== 4'd0) begin
      bad++;
      $display("FAIL idle_stay busy=%b sal=%0d want=0 0",
               busy1, sal1);
    end
    wr_en2 = 1'b1; wr_idx2 = 2'd3; wr_data2 = 4'd15;
    tick();
    wr_en2 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sal2 !== 4'(es[k])) begin
        bad++;
        $display("FAIL drop_wr[%0d] sal=%0d want=%0d",
                 k, sal2, es[k]);
      end
      if (k < 3) tick();
    end
    total++;
    if (step2 !== 2'd0) begin
      bad++;
      $display("FAIL wrap3 step=%0d want=0", step2);
    end
    halt();
  endtask

  task automatic test_async_reset();
    mode = 2'b00; dwell = 4'd0; en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (sal1 !== 4'd0 || step1 !== 2'd0 ||
        busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL async_rst sal=%0d step=%0d busy=%b want=0 0 0",
               sal1, step1, busy1);
    end
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sal1 !== 4'(k + 1) || done1 !== 1'b0) begin
        bad++;
        $display("FAIL rst_table[%0d] sal=%0d done=%b want=%0d 0",
                 k, sal1, done1, k + 1);
      end
      tick();
    end
    halt();
  endtask

  initial begin
    test_reset();
    test_wrap_default();
    test_pingpong();
    test_oneshot();
    test_en_and_writes();
    test_stop_start_and_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
